// File: rtl/digit_scan_pkg.sv
// digit_scan_pkg: shared definitions for the multiplexed digit scanner.
//   scan_state_t : scanner FSM state encoding
//   clog2()      : ceiling log2 with a floor of 1, for sizing indices/counters
package digit_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_next_idx.sv
// rr_next_idx: combinational circular search for the next set bit of mask
// strictly after cur, going upward and wrapping past NUM-1 back to 0.
// Ports:
//   cur     : starting index (excluded from the first pass, reached last)
//   mask    : candidate bitmap
//   nxt     : first set index found (cur when mask is empty)
//   wrapped : the search passed index NUM-1 before finding nxt
module rr_next_idx #(
  parameter int NUM   = 4,
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0] cur,
  input  logic [NUM-1:0]   mask,
  output logic [SEL_W-1:0] nxt,
  output logic             wrapped
);

  int               pos;
  int               idx;
  logic [SEL_W-1:0] idx_w;
  logic             found;

  always_comb begin
    nxt     = cur;
    wrapped = 1'b0;
    found   = 1'b0;
    pos     = 0;
    idx     = 0;
    idx_w   = '0;
    // k runs to NUM so a lone set bit at cur is found on the final step,
    // which always counts as a wrap.
    for (int k = 1; k <= NUM; k++) begin
      pos   = int'(cur) + k;
      idx   = (pos >= NUM) ? (pos - NUM) : pos;
      idx_w = SEL_W'(idx);
      if (!found && mask[idx_w]) begin
        found   = 1'b1;
        nxt     = idx_w;
        wrapped = (pos >= NUM);
      end
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: time-multiplexed display digit scanner with per-slot
// anti-ghosting blanking. Each slot is DWELL_CYCLES clocks: BLANK_CYCLES with
// all anodes off, then the selected anode driven.
// Ports:
//   clk         : rising-edge clock
//   rst         : synchronous active-high reset
//   en          : scan enable
//   digit_en    : per-digit enable mask
//   sel         : current digit index for the external segment mux
//   an_n        : active-low one-hot anode drive
//   blank       : high whenever all an_n bits are 1
//   frame_start : one-cycle pulse at the start of each scan frame
module digit_scan_ctrl
  import digit_scan_pkg::*;
#(
  parameter  int NUM_DIGITS   = 4,
  parameter  int DWELL_CYCLES = 16384,
  parameter  int BLANK_CYCLES = 64,
  localparam int SEL_W        = clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic [SEL_W-1:0]      sel,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  blank,
  output logic                  frame_start
);

  localparam int DW_W = clog2(DWELL_CYCLES);
  localparam logic [DW_W-1:0] BLANK_LAST = DW_W'(BLANK_CYCLES - 1);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);

  scan_state_t           state_q, state_d;
  logic [DW_W-1:0]       dwell_cnt_q, dwell_cnt_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic                  blank_q, blank_d;
  logic                  frame_start_q, frame_start_d;

  logic [SEL_W-1:0]      step_nxt, first_nxt;
  logic                  step_wrap, first_wrap;

  // Next enabled digit after the current one, for slot-to-slot advance.
  rr_next_idx #(.NUM(NUM_DIGITS), .SEL_W(SEL_W)) u_step (
    .cur     (sel_q),
    .mask    (digit_en),
    .nxt     (step_nxt),
    .wrapped (step_wrap)
  );

  // Searching upward from the top index yields the lowest enabled digit;
  // its wrap flag is always set, marking the start of a new frame.
  rr_next_idx #(.NUM(NUM_DIGITS), .SEL_W(SEL_W)) u_first (
    .cur     (SEL_W'(NUM_DIGITS - 1)),
    .mask    (digit_en),
    .nxt     (first_nxt),
    .wrapped (first_wrap)
  );

  always_comb begin
    state_d       = state_q;
    dwell_cnt_d   = dwell_cnt_q;
    sel_d         = sel_q;
    frame_start_d = 1'b0;
    an_n_d        = '1;
    blank_d       = 1'b1;

    if (!en || (digit_en == '0)) begin
      state_d     = ST_IDLE;
      dwell_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d       = ST_BLANK;
          dwell_cnt_d   = '0;
          sel_d         = first_nxt;
          frame_start_d = first_wrap;
        end
        ST_BLANK: begin
          dwell_cnt_d = dwell_cnt_q + 1'b1;
          if (dwell_cnt_q == BLANK_LAST) state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (dwell_cnt_q == DWELL_LAST) begin
            state_d       = ST_BLANK;
            dwell_cnt_d   = '0;
            sel_d         = step_nxt;
            frame_start_d = step_wrap;
          end else begin
            dwell_cnt_d = dwell_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          dwell_cnt_d = '0;
        end
      endcase
    end

    // A digit disabled mid-slot stays dark but keeps its slot timing.
    if ((state_d == ST_SHOW) && digit_en[sel_d]) begin
      an_n_d  = ~(NUM_DIGITS'(1) << sel_d);
      blank_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      dwell_cnt_q   <= '0;
      sel_q         <= '0;
      an_n_q        <= '1;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dwell_cnt_q   <= dwell_cnt_d;
      sel_q         <= sel_d;
      an_n_q        <= an_n_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign sel         = sel_q;
  assign an_n        = an_n_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;

endmodule
